cache_fill_fsm: RTL and testbench

- Miss handler sitting between a direct-mapped cache and the 16-bit byte-addressable word memory.
- On a cache miss it fetches one whole block from memory: 8 words of 16 bits, 16 bytes in total.
- Memory requests are issued back-to-back, one per cycle. Returning words are written into the cache data array in order, and the tag array is written when the last word lands.
- Memory read latency is variable; returned data is qualified by `memory_data_valid`.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_fill_fsm_if.sv | 39 +++
 rtl/cache_fill_fsm_fill_counter.sv | 25 ++
 rtl/cache_fill_fsm.sv | 122 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared constants, fill-state enum and block-address helper for the cache
// miss handler. Imported by the interface, the fill counter and the top.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH      = 16;
    localparam int unsigned DATA_WIDTH      = 16;
    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned WORD_BYTES      = 2;
    localparam int unsigned BLOCK_BYTES     = WORDS_PER_BLOCK * WORD_BYTES;
    localparam int unsigned WORD_SEL_BITS   = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned OFFSET_BITS     = WORD_SEL_BITS + 1;
    // One extra bit so the issue counter can reach WORDS_PER_BLOCK.
    localparam int unsigned CNT_BITS        = WORD_SEL_BITS + 1;
    localparam int unsigned MISS_CNT_BITS   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Byte address of the first byte of the block containing addr.
    function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~ADDR_WIDTH'(BLOCK_BYTES - 1);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bus between the cache/memory side and the miss handler.
//   miss_detected, miss_address        : cache lookup miss report
//   memory_data_valid, memory_data_in  : word returned by memory
//   fsm_busy                           : fill in progress (pipeline stall)
//   mem_enable, memory_address         : memory read request
//   write_data_array, data_word_sel,
//   data_out                           : cache data-array write port
//   write_tag_array                    : tag/valid write strobe
//   miss_count                         : fill counter (optional feature)
// slave = miss handler, master = surrounding cache and memory.
interface cache_fill_fsm_if;
    import cache_pkg::*;

    logic                     miss_detected;
    logic [ADDR_WIDTH-1:0]    miss_address;
    logic                     memory_data_valid;
    logic [DATA_WIDTH-1:0]    memory_data_in;
    logic                     fsm_busy;
    logic                     mem_enable;
    logic [ADDR_WIDTH-1:0]    memory_address;
    logic                     write_data_array;
    logic [WORD_SEL_BITS-1:0] data_word_sel;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     write_tag_array;
    logic [MISS_CNT_BITS-1:0] miss_count;

    modport master (
        output miss_detected, miss_address, memory_data_valid, memory_data_in,
        input  fsm_busy, mem_enable, memory_address, write_data_array,
               data_word_sel, data_out, write_tag_array, miss_count
    );

    modport slave (
        input  miss_detected, miss_address, memory_data_valid, memory_data_in,
        output fsm_busy, mem_enable, memory_address, write_data_array,
               data_word_sel, data_out, write_tag_array, miss_count
    );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and enable; used for the request issue
// index and the returned-word index of a block fill.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (dominates enable)
//   en       : increment
//   count    : current value
module fill_counter
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    output logic [CNT_BITS-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: on a miss, fetches the whole block from word memory with
// back-to-back read requests, writes returned words into the data array in
// order and strobes the tag array with the last word.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : cache_fill_fsm_if.slave (miss input, memory request/return,
//         data/tag array writes, busy, miss_count)
// Optional build macro CACHE_FILL_PERF_CNT_EN: adds a saturating count of
// started fills on miss_count; otherwise miss_count is tied to 0.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    cache_fill_fsm_if.slave bus
);

    fill_state_e           state, state_next;
    logic [ADDR_WIDTH-1:0] base;
    logic [CNT_BITS-1:0]   issue_cnt, recv_cnt;
    logic                  issue_en, recv_en, cnt_clr;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Block base captured when a fill starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            base <= '0;
        end else if (state == IDLE && bus.miss_detected) begin
            base <= block_base(bus.miss_address);
        end
    end

    // Next state and outputs; issuing and receiving run concurrently in FILL.
    always_comb begin
        state_next           = state;
        issue_en             = 1'b0;
        recv_en              = 1'b0;
        bus.fsm_busy         = 1'b0;
        bus.mem_enable       = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.data_word_sel    = '0;
        bus.data_out         = '0;
        bus.write_tag_array  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.miss_detected) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                bus.fsm_busy       = 1'b1;
                issue_en           = (issue_cnt < CNT_BITS'(WORDS_PER_BLOCK));
                bus.mem_enable     = issue_en;
                // Block base has zero offset bits, so the word offset never carries.
                bus.memory_address = base + ADDR_WIDTH'({issue_cnt, 1'b0});
                bus.data_word_sel  = recv_cnt[WORD_SEL_BITS-1:0];
                if (bus.memory_data_valid) begin
                    recv_en              = 1'b1;
                    bus.write_data_array = 1'b1;
                    bus.data_out         = bus.memory_data_in;
                    if (recv_cnt == CNT_BITS'(WORDS_PER_BLOCK - 1)) begin
                        bus.write_tag_array = 1'b1;
                        state_next          = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters are held at zero whenever the next cycle is not a fill cycle.
    assign cnt_clr = (state_next != FILL);

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (issue_en),
        .count (issue_cnt)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (recv_en),
        .count (recv_cnt)
    );

`ifdef CACHE_FILL_PERF_CNT_EN
    logic                     fill_start;
    logic [MISS_CNT_BITS-1:0] miss_cnt_q;

    assign fill_start = (state == IDLE) && (state_next == FILL);

    // Saturating count of started fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= '0;
        end else if (fill_start && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + MISS_CNT_BITS'(1);
        end
    end

    assign bus.miss_count = miss_cnt_q;
`else
    assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a latency-programmable memory model answers the
// DUT's requests; expected addresses and data-array writes are queued when a
// miss is driven and popped as the DUT issues requests and writes words.
module tb_cache_fill_fsm;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
        logic        last;
    } exp_wr_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } resp_t;

    logic clk;
    logic rst;

    cache_fill_fsm_if bus ();

    cache_fill_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_addr_q[$];
    exp_wr_t     exp_wr_q[$];
    resp_t       resp_q[$];

    int cyc = 0;
    int latency = 0;
    int fill_cyc0 = 0;
    int busy_cycles, en_cycles, wr_cnt, tag_cnt, tag_cyc, first_wr;
    int exp_miss = 0;
    bit model_on = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] exp_miss_count();
`ifdef CACHE_FILL_PERF_CNT_EN
        return 16'(exp_miss);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic clear_metrics();
        busy_cycles = 0;
        en_cycles   = 0;
        wr_cnt      = 0;
        tag_cnt     = 0;
        tag_cyc     = -1;
        first_wr    = -1;
    endtask

    // One clock: memory model reacts at negedge, DUT outputs sampled 1ns later.
    task automatic step();
        resp_t       r;
        logic [15:0] ea;
        exp_wr_t     ew;
        @(negedge clk);
        cyc++;
        if (bus.mem_enable) begin
            if (exp_addr_q.size() == 0) begin
                check_eq("addr_unexpected", 32'd1, 32'd0);
            end else begin
                ea = exp_addr_q.pop_front();
                check_eq("mem_addr", 32'(bus.memory_address), 32'(ea));
            end
            if (model_on) begin
                r.due  = cyc + latency;
                r.data = mem_word(bus.memory_address);
                resp_q.push_back(r);
            end
        end
        if (model_on) begin
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                r = resp_q.pop_front();
                bus.memory_data_valid = 1'b1;
                bus.memory_data_in    = r.data;
            end else begin
                bus.memory_data_valid = 1'b0;
                bus.memory_data_in    = 16'($urandom);
            end
        end
        #1;
        if (bus.fsm_busy)   busy_cycles++;
        if (bus.mem_enable) en_cycles++;
        if (bus.write_tag_array) begin
            tag_cnt++;
            tag_cyc = cyc - fill_cyc0;
        end
        if (bus.write_data_array) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc - fill_cyc0;
            if (exp_wr_q.size() == 0) begin
                check_eq("wr_unexpected", 32'd1, 32'd0);
            end else begin
                ew = exp_wr_q.pop_front();
                check_eq("word_sel", 32'(bus.data_word_sel), 32'(ew.sel));
                check_eq("data_out", 32'(bus.data_out), 32'(ew.data));
                check_eq("tag_with_last", 32'(bus.write_tag_array), 32'(ew.last));
            end
        end else if (bus.write_tag_array) begin
            check_eq("tag_stray", 32'd1, 32'd0);
        end
    endtask

    // Present a miss for one cycle and queue the block the DUT must fetch.
    task automatic do_miss(input logic [15:0] addr);
        logic [15:0] base;
        check_eq("busy_before_miss", 32'(bus.fsm_busy), 32'd0);
        base = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(base + 16'(2 * i));
            exp_wr_q.push_back('{sel: 3'(i), data: mem_word(base + 16'(2 * i)), last: (i == 7)});
        end
        exp_miss++;
        bus.miss_detected = 1'b1;
        bus.miss_address  = addr;
        fill_cyc0 = cyc;
        step();
        bus.miss_detected = 1'b0;
        check_eq("busy_after_miss", 32'(bus.fsm_busy), 32'd1);
    endtask

    // Full fill; inj > 0 re-presents a miss at 0x2000 in fill cycles inj..inj+1.
    task automatic run_fill(input string name, input logic [15:0] addr, input int lat,
                            input int inj, input int exp_busy, input int exp_first);
        int guard;
        latency = lat;
        clear_metrics();
        do_miss(addr);
        guard = 0;
        while (bus.fsm_busy && guard < 64) begin
            if (inj > 0 && cyc - fill_cyc0 == inj) begin
                bus.miss_detected = 1'b1;
                bus.miss_address  = 16'h2000;
            end else if (inj > 0 && cyc - fill_cyc0 == inj + 2) begin
                bus.miss_detected = 1'b0;
            end
            step();
            guard++;
        end
        bus.miss_detected = 1'b0;
        check_eq({name, "_timeout"},    32'(guard >= 64), 32'd0);
        check_eq({name, "_busy"},       32'(busy_cycles), 32'(exp_busy));
        check_eq({name, "_req_cycles"}, 32'(en_cycles), 32'd8);
        check_eq({name, "_first_wr"},   32'(first_wr), 32'(exp_first));
        check_eq({name, "_tag_cyc"},    32'(tag_cyc), 32'(exp_busy));
        check_eq({name, "_tag_cnt"},    32'(tag_cnt), 32'd1);
        check_eq({name, "_addr_left"},  32'(exp_addr_q.size()), 32'd0);
        check_eq({name, "_wr_left"},    32'(exp_wr_q.size()), 32'd0);
        check_eq({name, "_miss_count"}, 32'(bus.miss_count), 32'(exp_miss_count()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                   = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0000;
        bus.memory_data_valid = 1'b0;
        bus.memory_data_in    = 16'h0000;
        clear_metrics();
        step();
        step();
        check_eq("rst_busy",    32'(bus.fsm_busy), 32'd0);
        check_eq("rst_mem_en",  32'(bus.mem_enable), 32'd0);
        check_eq("rst_addr",    32'(bus.memory_address), 32'd0);
        check_eq("rst_wr",      32'(bus.write_data_array), 32'd0);
        check_eq("rst_sel",     32'(bus.data_word_sel), 32'd0);
        check_eq("rst_dout",    32'(bus.data_out), 32'd0);
        check_eq("rst_tag",     32'(bus.write_tag_array), 32'd0);
        check_eq("rst_miss_cnt", 32'(bus.miss_count), 32'd0);
        rst = 1'b0;
        step();

        // Returned-data valid while idle must not write anything.
        model_on = 1'b0;
        bus.memory_data_valid = 1'b1;
        bus.memory_data_in    = 16'hCAFE;
        step();
        check_eq("idle_valid_wr",  32'(bus.write_data_array), 32'd0);
        check_eq("idle_valid_tag", 32'(bus.write_tag_array), 32'd0);
        bus.memory_data_valid = 1'b0;
        model_on = 1'b1;
        step();

        run_fill("lat0",   16'h1236, 0, 0, 8, 1);
        step();
        run_fill("lat4",   16'h0040, 4, 0, 12, 5);
        step();
        run_fill("ignore", 16'h1230, 2, 3, 10, 3);
        run_fill("refill", 16'h2000, 0, 0, 8, 1);
        step();
        run_fill("wrap",   16'hFFFA, 1, 0, 9, 2);
        step();

        // Reset after three returned words.
        latency = 2;
        clear_metrics();
        do_miss(16'h1230);
        repeat (4) step();
        check_eq("pre_rst_words", 32'(wr_cnt), 32'd3);
        rst = 1'b1;
        model_on = 1'b0;
        bus.memory_data_valid = 1'b0;
        step();
        check_eq("post_rst_busy",  32'(bus.fsm_busy), 32'd0);
        check_eq("post_rst_mem_en", 32'(bus.mem_enable), 32'd0);
        check_eq("post_rst_tag",   32'(tag_cnt), 32'd0);
        rst = 1'b0;
        exp_miss = 0;
        exp_addr_q.delete();
        exp_wr_q.delete();
        resp_q.delete();
        step();
        bus.memory_data_valid = 1'b1;
        bus.memory_data_in    = 16'hBEEF;
        step();
        check_eq("late_valid_wr",  32'(bus.write_data_array), 32'd0);
        check_eq("late_valid_tag", 32'(bus.write_tag_array), 32'd0);
        check_eq("post_rst_miss_cnt", 32'(bus.miss_count), 32'd0);
        bus.memory_data_valid = 1'b0;
        model_on = 1'b1;
        step();

        run_fill("after_rst", 16'h0104, 3, 0, 11, 4);
        repeat (3) step();
        check_eq("final_miss_count", 32'(bus.miss_count), 32'(exp_miss_count()));
        check_eq("final_busy", 32'(bus.fsm_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
